gost_magma_core: RTL and testbench
==================================

// Module: gost_magma_core
// PURPOSE
//   Parametrised GOST 28147-89 / Magma (RFC 8891) 64-bit block cipher core, ECB, encrypt and decrypt.
//   Successor to the fixed single-mode core: adds a configurable number of rounds per cycle,
//   a selectable S-box set, valid/ready handshakes on input and output, and a key register.
//   Sits between the tile I/O shim and the host; one block is in flight at a time.
// PARAMETERS
//   ROUNDS_PER_CYCLE  1  Feistel rounds per clock: 1, 2, 4 or 8. Any other value is a $error at elaboration.
//   SBOX_SET          0  S-box table: 0 = id-tc26-gost-28147-param-Z (RFC 8891), 1 = id-GostR3411-94-TestParamSet.
// PORTS
//   clk        in   1    clock; all logic on the rising edge
//   rst        in   1    synchronous reset, active-high
//   key_we     in   1    write key_in into the key register (honoured only in IDLE)
//   key_in     in   256  key k255..k0; K1=k255..k224, ..., K8=k31..k0
//   key_err    out  1    1-cycle pulse: key_we arrived while not IDLE and was ignored
//   in_valid   in   1    input block valid
//   in_ready   out  1    core can accept a block (IDLE and key_we==0)
//   in_mode    in   1    0 = encrypt, 1 = decrypt; sampled on input handshake
//   in_data    in   64   block a = a1||a0 (a1 = [63:32], a0 = [31:0])
//   out_valid  out  1    result valid; held until out_ready
//   out_ready  in   1    consumer accepts the result
//   out_data   out  64   result block
//   busy       out  1    1 in RUN or DONE
// BEHAVIOUR
//   Reset, or rst high mid-operation:
//     - state goes to IDLE and any block in flight is dropped.
//     - in_ready=1, out_valid=0, out_data=0, busy=0, key_err=0; round counter=0.
//     - The key register is cleared to 0.
//   FSM:
//     - IDLE -> RUN on in_valid & in_ready: latch a1, a0 and mode; counter=0.
//     - RUN: each cycle performs ROUNDS_PER_CYCLE rounds; counter += ROUNDS_PER_CYCLE.
//     - RUN -> DONE on the edge where the counter reaches 32; out_valid rises.
//     - DONE -> IDLE on out_valid & out_ready; in_ready rises the following cycle.
//   Latency: handshake at edge t -> out_valid high after edge t+32/ROUNDS_PER_CYCLE
//     (32, 16, 8 or 4 cycles).
//   Throughput: one block per 32/ROUNDS_PER_CYCLE + 2 cycles, with out_ready held high.
//   Round i (i = 1..32), all arithmetic mod 2^32:
//     - g(x) = ROL11(S(x + Ki)).
//     - S applies eight 4-bit boxes; box 0 acts on nibble [3:0].
//     - Rounds 1..31: (a1, a0) <- (a0, g(a0) ^ a1).
//     - Round 32 does no swap: out_data = (g(a0) ^ a1) || a0.
//   Round-key order:
//     - Encrypt: K1..K8, K1..K8, K1..K8, K8..K1.
//     - Decrypt: K1..K8, K8..K1, K8..K1, K8..K1.
//   Key:
//     - key_we in IDLE writes the key register at that edge; in_ready=0 in that cycle,
//       so a block offered at the same time is accepted on the next cycle with the new key.
//     - key_we in RUN or DONE is ignored and key_err pulses for 1 cycle.
//   Backpressure: out_data and out_valid stay stable in DONE while out_ready=0.
//     in_valid with in_ready=0 has no effect.
//   out_data keeps its last value after it is consumed; it is only meaningful while out_valid=1.
// TESTING
//   T1 RFC 8891 encrypt (SBOX_SET=0), key ffeeddccbbaa99887766554433221100f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff,
//      in fedcba9876543210 -> out_data 4ee901e5c2d8ca3d.
//   T2 Same key, decrypt 4ee901e5c2d8ca3d -> fedcba9876543210.
//   T3 Run T1 for ROUNDS_PER_CYCLE = 1, 2, 4, 8 -> identical result;
//      out_valid exactly 32, 16, 8, 4 cycles after the handshake.
//   T4 Hold out_ready=0 for 10 cycles in DONE -> out_valid and out_data stable, in_ready=0;
//      then release it -> in_ready=1 one cycle later.
//   T5 key_we pulse in RUN -> key_err pulse, result still 4ee901e5c2d8ca3d.
//      key_we and in_valid in the same IDLE cycle -> block accepted next cycle and uses the new key.
//   T6 rst asserted in the middle of RUN -> outputs at reset values next cycle, no out_valid.
//      After reloading the key, T1 passes again.

Source files
------------

// File: rtl/gost_magma_core.sv
// GOST 28147-89 / Magma (RFC 8891) 64-bit block cipher core, ECB encrypt/decrypt,
// ROUNDS_PER_CYCLE Feistel rounds per clock, one block in flight, valid/ready handshakes.
module gost_magma_core #(
   parameter int ROUNDS_PER_CYCLE = 1,
   parameter int SBOX_SET         = 0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         key_we,
   input  logic [255:0] key_in,
   output logic         key_err,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic         in_mode,
   input  logic [63:0]  in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [63:0]  out_data,
   output logic         busy
);

   if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 ||
         ROUNDS_PER_CYCLE == 4 || ROUNDS_PER_CYCLE == 8)) begin : g_bad_rpc
      $error("gost_magma_core: ROUNDS_PER_CYCLE must be 1, 2, 4 or 8");
   end
   if (!(SBOX_SET == 0 || SBOX_SET == 1)) begin : g_bad_sbox
      $error("gost_magma_core: SBOX_SET must be 0 or 1");
   end

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   // Row b is box b, acting on nibble [4b+3:4b].
   localparam logic [3:0] SBOX_Z [0:7][0:15] = '{
      '{4'd12, 4'd4,  4'd6,  4'd2,  4'd10, 4'd5,  4'd11, 4'd9,  4'd14, 4'd8,  4'd13, 4'd7,  4'd0,  4'd3,  4'd15, 4'd1},
      '{4'd6,  4'd8,  4'd2,  4'd3,  4'd9,  4'd10, 4'd5,  4'd12, 4'd1,  4'd14, 4'd4,  4'd7,  4'd11, 4'd13, 4'd0,  4'd15},
      '{4'd11, 4'd3,  4'd5,  4'd8,  4'd2,  4'd15, 4'd10, 4'd13, 4'd14, 4'd1,  4'd7,  4'd4,  4'd12, 4'd9,  4'd6,  4'd0},
      '{4'd12, 4'd8,  4'd2,  4'd1,  4'd13, 4'd4,  4'd15, 4'd6,  4'd7,  4'd0,  4'd10, 4'd5,  4'd3,  4'd14, 4'd9,  4'd11},
      '{4'd7,  4'd15, 4'd5,  4'd10, 4'd8,  4'd1,  4'd6,  4'd13, 4'd0,  4'd9,  4'd3,  4'd14, 4'd11, 4'd4,  4'd2,  4'd12},
      '{4'd5,  4'd13, 4'd15, 4'd6,  4'd9,  4'd2,  4'd12, 4'd10, 4'd11, 4'd7,  4'd8,  4'd1,  4'd4,  4'd3,  4'd14, 4'd0},
      '{4'd8,  4'd14, 4'd2,  4'd5,  4'd6,  4'd9,  4'd1,  4'd12, 4'd15, 4'd4,  4'd11, 4'd0,  4'd13, 4'd10, 4'd3,  4'd7},
      '{4'd1,  4'd7,  4'd14, 4'd13, 4'd0,  4'd5,  4'd8,  4'd3,  4'd4,  4'd15, 4'd10, 4'd6,  4'd9,  4'd12, 4'd11, 4'd2}
   };
   localparam logic [3:0] SBOX_T [0:7][0:15] = '{
      '{4'd4,  4'd10, 4'd9,  4'd2,  4'd13, 4'd8,  4'd0,  4'd14, 4'd6,  4'd11, 4'd1,  4'd12, 4'd7,  4'd15, 4'd5,  4'd3},
      '{4'd14, 4'd11, 4'd4,  4'd12, 4'd6,  4'd13, 4'd15, 4'd10, 4'd2,  4'd3,  4'd8,  4'd1,  4'd0,  4'd7,  4'd5,  4'd9},
      '{4'd5,  4'd8,  4'd1,  4'd13, 4'd10, 4'd3,  4'd4,  4'd2,  4'd14, 4'd15, 4'd12, 4'd7,  4'd6,  4'd0,  4'd9,  4'd11},
      '{4'd7,  4'd13, 4'd10, 4'd1,  4'd0,  4'd8,  4'd9,  4'd15, 4'd14, 4'd4,  4'd6,  4'd12, 4'd11, 4'd2,  4'd5,  4'd3},
      '{4'd6,  4'd12, 4'd7,  4'd1,  4'd5,  4'd15, 4'd13, 4'd8,  4'd4,  4'd10, 4'd9,  4'd14, 4'd0,  4'd3,  4'd11, 4'd2},
      '{4'd4,  4'd11, 4'd10, 4'd0,  4'd7,  4'd2,  4'd1,  4'd13, 4'd3,  4'd6,  4'd8,  4'd5,  4'd9,  4'd12, 4'd15, 4'd14},
      '{4'd13, 4'd11, 4'd4,  4'd1,  4'd3,  4'd15, 4'd5,  4'd9,  4'd0,  4'd10, 4'd14, 4'd7,  4'd6,  4'd8,  4'd2,  4'd12},
      '{4'd1,  4'd15, 4'd13, 4'd0,  4'd5,  4'd7,  4'd10, 4'd4,  4'd9,  4'd2,  4'd3,  4'd14, 4'd6,  4'd11, 4'd8,  4'd12}
   };

   function automatic logic [31:0] g_func(input logic [31:0] x);
      logic [31:0] s;
      s = '0;
      for (int unsigned b = 0; b < 8; b++) begin
         s[4*b +: 4] = (SBOX_SET == 0) ? SBOX_Z[b][x[4*b +: 4]] : SBOX_T[b][x[4*b +: 4]];
      end
      return {s[20:0], s[31:21]};
   endfunction

   function automatic logic [31:0] round_key(input logic [255:0] key, input logic dec,
                                             input logic [4:0] idx);
      logic [2:0] k;
      if (dec ? (idx < 5'd8) : (idx < 5'd24)) k = idx[2:0];
      else                                   k = 3'd7 - idx[2:0];
      return key[255 - 32*int'(k) -: 32];
   endfunction

   state_t         state_q, state_d;
   logic [31:0]    a1_q, a1_d, a0_q, a0_d;
   logic           mode_q, mode_d;
   logic [5:0]     ctr_q, ctr_d;
   logic [255:0]   key_q, key_d;
   logic [63:0]    out_data_q, out_data_d;
   logic           key_err_q, key_err_d;

   logic [31:0]    rnd_a1, rnd_a0, rnd_tmp;
   logic [4:0]     rnd_idx;

   always_comb begin
      rnd_a1  = a1_q;
      rnd_a0  = a0_q;
      rnd_tmp = '0;
      rnd_idx = '0;
      for (int unsigned r = 0; r < ROUNDS_PER_CYCLE; r++) begin
         rnd_idx = ctr_q[4:0] + 5'(r);
         rnd_tmp = g_func(rnd_a0 + round_key(key_q, mode_q, rnd_idx)) ^ rnd_a1;
         rnd_a1  = rnd_a0;
         rnd_a0  = rnd_tmp;
      end
   end

   // Every round swaps; the unswapped final round is recovered by emitting the halves reversed.
   always_comb begin
      state_d    = state_q;
      a1_d       = a1_q;
      a0_d       = a0_q;
      mode_d     = mode_q;
      ctr_d      = ctr_q;
      key_d      = key_q;
      out_data_d = out_data_q;
      key_err_d  = key_we && (state_q != IDLE);
      case (state_q)
         IDLE: begin
            if (key_we) begin
               key_d = key_in;
            end else if (in_valid) begin
               state_d = RUN;
               a1_d    = in_data[63:32];
               a0_d    = in_data[31:0];
               mode_d  = in_mode;
               ctr_d   = '0;
            end
         end
         RUN: begin
            a1_d  = rnd_a1;
            a0_d  = rnd_a0;
            ctr_d = ctr_q + 6'(ROUNDS_PER_CYCLE);
            if (ctr_d == 6'd32) begin
               state_d    = DONE;
               out_data_d = {rnd_a0, rnd_a1};
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         a1_q       <= '0;
         a0_q       <= '0;
         mode_q     <= 1'b0;
         ctr_q      <= '0;
         key_q      <= '0;
         out_data_q <= '0;
         key_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         a1_q       <= a1_d;
         a0_q       <= a0_d;
         mode_q     <= mode_d;
         ctr_q      <= ctr_d;
         key_q      <= key_d;
         out_data_q <= out_data_d;
         key_err_q  <= key_err_d;
      end
   end

   assign in_ready  = (state_q == IDLE) && !key_we;
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign out_data  = out_data_q;
   assign key_err   = key_err_q;

endmodule

// File: tb/tb_gost_magma_core.sv
// Directed bench for gost_magma_core: known-answer vectors plus handshake, latency,
// key-write and reset corner cases on instances with 1, 2, 4 and 8 rounds per cycle.
module tb_gost_magma_core;

   localparam logic [255:0] RFC_KEY =
      256'hffeeddccbbaa99887766554433221100f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
   localparam logic [63:0] PT1 = 64'hfedcba9876543210;
   localparam logic [63:0] CT1 = 64'h4ee901e5c2d8ca3d;

   logic         clk, rst, key_we, in_valid, in_mode, out_ready;
   logic [255:0] key_in;
   logic [63:0]  in_data;
   logic         key_err_w [4];
   logic         in_ready_w [4];
   logic         out_valid_w [4];
   logic         busy_w [4];
   logic [63:0]  out_data_w [4];

   int total = 0;
   int bad   = 0;

   for (genvar gi = 0; gi < 4; gi++) begin : g_dut
      gost_magma_core #(.ROUNDS_PER_CYCLE(1 << gi), .SBOX_SET(0)) u_dut (
         .clk       (clk),
         .rst       (rst),
         .key_we    (key_we),
         .key_in    (key_in),
         .key_err   (key_err_w[gi]),
         .in_valid  (in_valid),
         .in_ready  (in_ready_w[gi]),
         .in_mode   (in_mode),
         .in_data   (in_data),
         .out_valid (out_valid_w[gi]),
         .out_ready (out_ready),
         .out_data  (out_data_w[gi]),
         .busy      (busy_w[gi])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic        mode;
      logic [63:0] din;
      logic [63:0] dout;
   } vec_t;

   vec_t vecs [10];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_ne(input string name, input logic [63:0] act, input logic [63:0] nexp);
      total++;
      if (act === nexp) begin
         bad++;
         $display("FAIL %s: got %h required anything but %h", name, act, nexp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic load_key(input logic [255:0] k);
      key_in = k;
      key_we = 1'b1;
      tick();
      key_we = 1'b0;
   endtask

   task automatic start_block(input logic mode, input logic [63:0] data);
      int n;
      n = 0;
      while (!in_ready_w[0] && n < 100) begin
         tick();
         n++;
      end
      if (!in_ready_w[0]) begin
         total++;
         bad++;
         $display("FAIL in_ready_timeout: got 0 expected 1");
      end
      in_valid = 1'b1;
      in_mode  = mode;
      in_data  = data;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_result(output logic [63:0] res, output int lat);
      lat = 0;
      while (!out_valid_w[0] && lat < 200) begin
         tick();
         lat++;
      end
      if (!out_valid_w[0]) begin
         total++;
         bad++;
         $display("FAIL out_valid_timeout: got 0 expected 1");
      end
      res = out_data_w[0];
   endtask

   task automatic consume();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic run_block(input logic mode, input logic [63:0] data,
                            output logic [63:0] res, output int lat);
      start_block(mode, data);
      wait_result(res, lat);
      consume();
   endtask

   initial begin
      logic [63:0] res;
      int          lat;
      int          lats [4];
      logic [63:0] ress [4];
      logic        seen;

      vecs[0] = '{1'b0, PT1, CT1};
      vecs[1] = '{1'b1, CT1, PT1};
      vecs[2] = '{1'b0, 64'h92def06b3c130a59, 64'h2b073f0494f372a0};
      vecs[3] = '{1'b0, 64'hdb54c704f8189d20, 64'hde70e715d3556e48};
      vecs[4] = '{1'b0, 64'h4a98fb2e67a8024c, 64'h11d8d9e9eacfbc1e};
      vecs[5] = '{1'b0, 64'h8912409b17b57e41, 64'h7c68260996c67efb};
      vecs[6] = '{1'b1, 64'h2b073f0494f372a0, 64'h92def06b3c130a59};
      vecs[7] = '{1'b1, 64'hde70e715d3556e48, 64'hdb54c704f8189d20};
      vecs[8] = '{1'b1, 64'h11d8d9e9eacfbc1e, 64'h4a98fb2e67a8024c};
      vecs[9] = '{1'b1, 64'h7c68260996c67efb, 64'h8912409b17b57e41};

      rst = 1'b1; key_we = 1'b0; key_in = '0; in_valid = 1'b0;
      in_mode = 1'b0; in_data = '0; out_ready = 1'b0;
      do_reset();

      for (int k = 0; k < 4; k++) begin
         check($sformatf("rst_in_ready_%0d", k),  64'(in_ready_w[k]),  64'd1);
         check($sformatf("rst_out_valid_%0d", k), 64'(out_valid_w[k]), 64'd0);
         check($sformatf("rst_out_data_%0d", k),  out_data_w[k],       64'd0);
         check($sformatf("rst_busy_%0d", k),      64'(busy_w[k]),      64'd0);
         check($sformatf("rst_key_err_%0d", k),   64'(key_err_w[k]),   64'd0);
      end

      load_key(RFC_KEY);
      for (int i = 0; i < 10; i++) begin
         run_block(vecs[i].mode, vecs[i].din, res, lat);
         check($sformatf("vec%0d_data", i), res, vecs[i].dout);
         check($sformatf("vec%0d_latency", i), 64'(lat), 64'd32);
      end

      // All four instances in lockstep: same result, latency 32/R.
      do_reset();
      load_key(RFC_KEY);
      in_valid = 1'b1; in_mode = 1'b0; in_data = PT1;
      tick();
      in_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         lats[k] = 0;
         ress[k] = '0;
      end
      for (int c = 1; c <= 40; c++) begin
         tick();
         for (int k = 0; k < 4; k++) begin
            if (out_valid_w[k] && lats[k] == 0) begin
               lats[k] = c;
               ress[k] = out_data_w[k];
            end
         end
      end
      for (int k = 0; k < 4; k++) begin
         check($sformatf("rpc%0d_latency", 1 << k), 64'(lats[k]), 64'(32 >> k));
         check($sformatf("rpc%0d_data", 1 << k), ress[k], CT1);
      end
      consume();

      // Backpressure in DONE.
      start_block(1'b0, PT1);
      wait_result(res, lat);
      for (int c = 0; c < 10; c++) begin
         tick();
         check("bp_out_valid", 64'(out_valid_w[0]), 64'd1);
         check("bp_out_data", out_data_w[0], CT1);
         check("bp_in_ready", 64'(in_ready_w[0]), 64'd0);
      end
      out_ready = 1'b1;
      #1;
      check("bp_in_ready_release_cycle", 64'(in_ready_w[0]), 64'd0);
      tick();
      out_ready = 1'b0;
      check("bp_in_ready_after", 64'(in_ready_w[0]), 64'd1);
      check("bp_out_valid_after", 64'(out_valid_w[0]), 64'd0);

      // key_we during RUN is ignored and flagged.
      start_block(1'b0, PT1);
      for (int c = 0; c < 5; c++) tick();
      key_in = '1;
      key_we = 1'b1;
      tick();
      key_we = 1'b0;
      check("kerr_pulse", 64'(key_err_w[0]), 64'd1);
      check("kerr_busy", 64'(busy_w[0]), 64'd1);
      tick();
      check("kerr_pulse_end", 64'(key_err_w[0]), 64'd0);
      wait_result(res, lat);
      check("kerr_data", res, CT1);
      consume();

      // key_we and in_valid together in IDLE: block waits one cycle and uses the new key.
      do_reset();
      key_in = RFC_KEY; key_we = 1'b1;
      in_valid = 1'b1; in_mode = 1'b0; in_data = PT1;
      #1;
      check("kw_iv_in_ready_low", 64'(in_ready_w[0]), 64'd0);
      tick();
      key_we = 1'b0;
      #1;
      check("kw_iv_in_ready_next", 64'(in_ready_w[0]), 64'd1);
      tick();
      in_valid = 1'b0;
      check("kw_iv_busy", 64'(busy_w[0]), 64'd1);
      wait_result(res, lat);
      check("kw_iv_data", res, CT1);
      check("kw_iv_latency", 64'(lat), 64'd32);
      consume();

      // Reset mid-RUN drops the block and clears the key.
      start_block(1'b0, PT1);
      for (int c = 0; c < 10; c++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid_rst_in_ready", 64'(in_ready_w[0]), 64'd1);
      check("mid_rst_out_valid", 64'(out_valid_w[0]), 64'd0);
      check("mid_rst_out_data", out_data_w[0], 64'd0);
      check("mid_rst_busy", 64'(busy_w[0]), 64'd0);
      check("mid_rst_key_err", 64'(key_err_w[0]), 64'd0);
      seen = 1'b0;
      for (int c = 0; c < 40; c++) begin
         tick();
         if (out_valid_w[0]) seen = 1'b1;
      end
      check("mid_rst_no_out_valid", 64'(seen), 64'd0);
      run_block(1'b0, PT1, res, lat);
      check_ne("mid_rst_key_cleared", res, CT1);
      load_key(RFC_KEY);
      run_block(1'b0, PT1, res, lat);
      check("mid_rst_reload_data", res, CT1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
